// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the asynchronous FIFO (read clock domain).
// It pops the FIFO whenever there is room for the word, and it absorbs the
// FIFO's one-cycle registered read latency in a 2-entry skid buffer. Words
// leave on a valid/ready stream at up to one per cycle. A wrapping counter
// records how many words were delivered.
module fifo_rd_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] rd_count
);

  logic [WIDTH-1:0] r_buf [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [CNT_W-1:0] r_count;

  logic             w_hs;
  logic [1:0]       w_level;
  logic             w_pop_ok;

  // Output view of the buffer head, and pop permission.
  // A pop is allowed at a level of 2 only when a word leaves this cycle,
  // which keeps 1 word/cycle through the combinational m_ready path.
  always_comb begin
    m_valid    = (r_occ != 2'd0);
    m_data     = r_buf[r_head];
    rd_count   = r_count;
    w_hs       = m_valid & m_ready;
    w_level    = r_occ + {1'b0, r_inflight};
    w_pop_ok   = (w_level < 2'd2) || ((w_level == 2'd2) && w_hs);
    fifo_rd_en = !rd_rst && !fifo_empty && w_pop_ok;
  end

  // Capture the returning FIFO word into the tail slot and track the pop that is in flight.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_tail     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (r_inflight) begin
        r_buf[r_tail] <= fifo_rd_data;
        r_tail        <= ~r_tail;
      end
    end
  end

  // Advance the head on a handshake and count the delivered words. The counter wraps silently.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_head  <= 1'b0;
      r_count <= '0;
    end else if (w_hs) begin
      r_head  <= ~r_head;
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Occupancy. A capture and a handshake in the same cycle cancel each other.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_occ <= '0;
    end else begin
      case ({r_inflight, w_hs})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. The bench emulates the FIFO as a queue of source
// words. A model tracks which words were popped, which words are held and
// which words were delivered, and one compare process checks the DUT every
// cycle. The stimulus is directed and also checks hand-computed literals. A
// second instance with a 4-bit counter exercises the counter wrap.
module tb_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en, fifo_rd_en4;
  logic [7:0] fifo_rd_data = 8'hEE;
  logic       m_valid, m_valid4;
  logic       m_ready = 1'b0;
  logic [7:0] m_data, m_data4;
  logic [15:0] rd_count;
  logic [3:0]  rd_count4;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO emulation and model state
  logic [7:0] src [$];
  logic [7:0] exp_q [$];
  int         occ_m = 0;
  bit         infl_m = 0;
  bit         known = 0;
  int         delivered = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rd_count(rd_count)
  );

  fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en4),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .rd_count(rd_count4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus the FIFO read-data emulation
  initial begin : compare
    bit         en, hs;
    bit         pend;
    logic [7:0] pdata;
    int         lvl;
    pend = 0;
    pdata = 8'h00;
    forever begin
      @(negedge rd_clk);
      #2;
      en = fifo_rd_en;
      hs = known && (occ_m != 0) && m_ready;
      if (rd_rst || fifo_empty) chk("rd_en_idle", {31'd0, fifo_rd_en}, 32'd0);
      else if (known) begin
        lvl = occ_m + int'(infl_m) - int'(hs);
        chk("rd_en_rule", {31'd0, fifo_rd_en}, {31'd0, (lvl < 2)});
      end
      if (known) begin
        chk("m_valid", {31'd0, m_valid}, {31'd0, (occ_m != 0)});
        if (occ_m != 0) chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
        chk("rd_count", {16'd0, rd_count}, delivered & 32'hFFFF);
        chk("rd_count4", {28'd0, rd_count4}, delivered & 32'hF);
      end
      pend = 0;
      if (rd_rst) begin
        exp_q.delete();
        occ_m = 0;
        infl_m = 0;
        delivered = 0;
        known = 1;
      end else if (known) begin
        if (hs) begin
          void'(exp_q.pop_front());
          delivered++;
          occ_m--;
        end
        if (infl_m) occ_m++;
        infl_m = en;
        if (en && src.size() > 0) begin
          pdata = src.pop_front();
          exp_q.push_back(pdata);
          pend = 1;
        end
        chk("level_le_2", {31'd0, (occ_m + int'(infl_m) <= 2)}, 32'd1);
      end
      @(posedge rd_clk);
      #1;
      fifo_rd_data = pend ? pdata : 8'hEE;
    end
  end

  task automatic step(input bit r, input bit hold, input bit rdy);
    @(negedge rd_clk);
    rd_rst = r;
    m_ready = rdy;
    fifo_empty = hold || (src.size() == 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  initial begin : stim
    int t_pop, t_val, pops, vcnt, k;
    logic [7:0] d_val;

    // 1: reset held with a non-empty FIFO
    src.push_back(8'h11);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      #3;
      chk("t1_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("t1_valid", {31'd0, m_valid}, 32'd0);
      chk("t1_count", {16'd0, rd_count}, 32'd0);
    end
    drain(6);

    // 2: a single word
    step(1, 1, 1); step(1, 1, 1);
    src.push_back(8'hA5);
    step(0, 1, 1); step(0, 1, 1);
    t_pop = -1; t_val = -1; d_val = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1);
      #3;
      if (fifo_rd_en && t_pop < 0) t_pop = i;
      if (m_valid && t_val < 0) begin t_val = i; d_val = m_data; end
    end
    chk("t2_pop_cycle", t_pop, 0);
    chk("t2_latency", t_val - t_pop, 2);
    chk("t2_data", {24'd0, d_val}, 32'hA5);
    chk("t2_count", {16'd0, rd_count}, 32'd1);

    // 3: streaming 0x00..0x0F
    step(1, 0, 1); step(1, 0, 1);
    for (int w = 0; w < 16; w++) src.push_back(8'(w));
    t_val = -1; vcnt = 0; k = -1;
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 1);
      #3;
      if (m_valid) begin
        if (t_val < 0) t_val = i;
        k = i;
        vcnt++;
      end
    end
    chk("t3_first_valid", t_val, 2);
    chk("t3_no_gaps", k - t_val, 15);
    chk("t3_valid_cycles", vcnt, 16);
    chk("t3_count", {16'd0, rd_count}, 32'd16);

    // 4: backpressure
    step(1, 0, 0); step(1, 0, 0);
    for (int w = 0; w < 4; w++) src.push_back(8'h30 + 8'(w));
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      #3;
      if (fifo_rd_en) pops++;
    end
    chk("t4_pops", pops, 2);
    chk("t4_hold_valid", {31'd0, m_valid}, 32'd1);
    chk("t4_hold_data", {24'd0, m_data}, 32'h30);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      #3;
      if (m_valid) vcnt++;
    end
    chk("t4_no_gap", vcnt, 4);
    drain(3);
    chk("t4_count", {16'd0, rd_count}, 32'd4);

    // 5: random ready and empty toggling, 1000 words
    step(1, 0, 0); step(1, 0, 0);
    for (int w = 0; w < 1000; w++) src.push_back(8'($urandom));
    k = 0;
    while (delivered < 1000 && k < 10000) begin
      step(0, ($urandom_range(0, 3) == 0), 1'($urandom));
      k++;
    end
    step(0, 0, 0);
    #3;
    chk("t5_count", {16'd0, rd_count}, 32'd1000);
    chk("t5_src_empty", src.size(), 0);

    // 6: counter wrap on the 4-bit instance, then reset with a full buffer
    step(1, 0, 1); step(1, 0, 1);
    for (int w = 0; w < 17; w++) src.push_back(8'h80 + 8'(w));
    drain(24);
    #3;
    chk("t6_wrap4", {28'd0, rd_count4}, 32'd1);
    chk("t6_count16", {16'd0, rd_count}, 32'd17);
    for (int w = 0; w < 4; w++) src.push_back(8'hC0 + 8'(w));
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    #3;
    chk("t6_full_valid", {31'd0, m_valid}, 32'd1);
    chk("t6_full_no_pop", {31'd0, fifo_rd_en}, 32'd0);
    step(1, 0, 0);
    step(0, 0, 0);
    #3;
    chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_rst_count", {16'd0, rd_count}, 32'd0);
    chk("t6_rst_count4", {28'd0, rd_count4}, 32'd0);
    drain(8);
    #3;
    chk("t6_after_count", {16'd0, rd_count}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
